// File: rtl/seg_pipe_adder_pkg.sv
// seg_pipe_adder_pkg
// Shared constants for the segmented pipelined adder: default operand width,
// default slice width and the stage-count derivation used by the top level.
// No ports (package).
package seg_pipe_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Number of pipeline stages: one stage per SEG-bit slice of the operands.
  function automatic int calc_nstg(input int width, input int seg);
    return width / seg;
  endfunction

  localparam int DEF_NSTG = calc_nstg(DEF_WIDTH, DEF_SEG);

endpackage

// File: rtl/seg_pipe_adder_if.sv
// seg_pipe_adder_if
// Bus bundle between a requester and the segmented pipelined adder.
//   en        pipeline advance (0 = hold everything)
//   flush     synchronous clear of all in-flight valid bits
//   in_valid  a/b/cin/sub carry an operation this cycle
//   a, b      operands (WIDTH bits)
//   cin       carry-in, ignored for subtraction
//   sub       0 = a+b+cin, 1 = a-b
//   out_valid sum/cout/ovf carry a result this cycle
//   sum       result modulo 2^WIDTH
//   cout      carry out of the MSB (for subtraction 1 = no borrow)
//   ovf       two's-complement signed overflow
// Modports: master drives the request side, slave is the adder.
interface seg_pipe_adder_if
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output en, flush, in_valid, a, b, cin, sub,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  en, flush, in_valid, a, b, cin, sub,
    output out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/seg_pipe_adder_adder_seg.sv
// adder_seg
// Combinational SEG-bit ripple-carry adder built from per-bit full adders.
//   a, b  slice operands (SEG bits)
//   cin   carry into bit 0
//   sum   slice sum (SEG bits)
//   cout  carry out of the top bit
module adder_seg
  import seg_pipe_adder_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[SEG];

endmodule

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder
// Pipelined adder/subtractor that adds one SEG-bit slice per stage.
// Stage k adds slice k of the operands with the carry from stage k-1; the
// untouched upper operand slices and the finished lower sum slices travel
// with the operation so the full result leaves the last stage aligned.
// Latency is NSTG enabled cycles, throughput one operation per cycle.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg_pipe_adder_if slave modport (request + result)
module seg_pipe_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input logic            clk,
  input logic            rst_n,
  seg_pipe_adder_if.slave bus
);

  localparam int NSTG = calc_nstg(WIDTH, SEG);
  localparam int MSB  = WIDTH - 1;

  // Per-stage inputs (what stage k sees) and registered stage state.
  logic [WIDTH-1:0] a_in [NSTG];
  logic [WIDTH-1:0] b_in [NSTG];
  logic [WIDTH-1:0] s_in [NSTG];
  logic             c_in [NSTG];
  logic             v_in [NSTG];

  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic             c_q [NSTG];
  logic             v_q [NSTG];
  logic             ovf_q;

  // Subtraction is folded in at capture: B is inverted and the carry-in
  // forced to 1, so later stages never need to know the mode.
  assign a_in[0] = bus.a;
  assign b_in[0] = bus.sub ? ~bus.b : bus.b;
  assign c_in[0] = bus.sub | bus.cin;
  assign s_in[0] = '0;
  assign v_in[0] = bus.in_valid;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [SEG-1:0]   slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] sum_nxt;

    if (k > 0) begin : g_link
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a    (a_in[k][k*SEG +: SEG]),
      .b    (b_in[k][k*SEG +: SEG]),
      .cin  (c_in[k]),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    // Merge this stage's slice into the partial sum carried from below.
    always_comb begin
      sum_nxt                = s_in[k];
      sum_nxt[k*SEG +: SEG]  = slice_sum;
    end

    // Flush clears valid even while stalled; data only moves when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end else begin
        if (bus.flush) begin
          v_q[k] <= 1'b0;
        end else if (bus.en) begin
          v_q[k] <= v_in[k];
        end
        if (bus.en) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= sum_nxt;
          c_q[k] <= slice_cout;
        end
      end
    end

    // Overflow is resolved in the last stage where the top sum bit exists.
    if (k == NSTG - 1) begin : g_ovf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (bus.en) begin
          ovf_q <= (a_in[k][MSB] == b_in[k][MSB]) && (sum_nxt[MSB] != a_in[k][MSB]);
        end
      end
    end
  end

  assign bus.out_valid = v_q[NSTG-1];
  assign bus.sum       = s_q[NSTG-1];
  assign bus.cout      = c_q[NSTG-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb_seg_pipe_adder
// Scoreboard bench for seg_pipe_adder (WIDTH=32, SEG=8, four stages).
// Expected results are queued when an operation is accepted, tagged with the
// enabled-cycle count at which they must appear, and compared on arrival.
module tb_seg_pipe_adder;

  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int NSTG  = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               due;
  } exp_t;

  logic clk;
  logic rst_n;

  seg_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  seg_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             sb[$];
  int               adv;
  logic             exp_ov;
  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             exp_ovf;
  int               n_tests;
  int               n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         m;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   r;
    bb    = sub ? ~b : b;
    r     = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub | cin)};
    m.sum  = r[WIDTH-1:0];
    m.cout = r[WIDTH];
    m.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    m.due  = 0;
    return m;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: queue an accepted operation, advance the model, compare.
  task automatic tick(input exp_t e);
    logic en_now;
    logic flush_now;
    en_now    = bus.en;
    flush_now = bus.flush;
    if (bus.en && !bus.flush && bus.in_valid && rst_n) begin
      e.due = adv + NSTG;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (en_now) adv++;
    if (flush_now) begin
      sb.delete();
      exp_ov = 1'b0;
    end else if (en_now) begin
      if (sb.size() > 0 && sb[0].due == adv) begin
        e        = sb.pop_front();
        exp_ov   = 1'b1;
        exp_sum  = e.sum;
        exp_cout = e.cout;
        exp_ovf  = e.ovf;
      end else begin
        exp_ov = 1'b0;
      end
    end
    check_output("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check_output("sum",  64'(bus.sum),  64'(exp_sum));
      check_output("cout", 64'(bus.cout), 64'(exp_cout));
      check_output("ovf",  64'(bus.ovf),  64'(exp_ovf));
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic flush, input logic iv,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic sub);
    bus.en       = en;
    bus.flush    = flush;
    bus.in_valid = iv;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
  endtask

  task automatic issue_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub,
                           input logic [WIDTH-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.due = 0;
    apply_stimulus(1'b1, 1'b0, 1'b1, a, b, cin, sub);
    tick(e);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    apply_stimulus(1'b1, 1'b0, 1'b1, a, b, cin, sub);
    tick(model(a, b, cin, sub));
  endtask

  task automatic idle(input int n);
    exp_t e;
    e = model('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, "_sum"},       64'(bus.sum),       64'd0);
    check_output({tag, "_cout"},      64'(bus.cout),      64'd0);
    check_output({tag, "_ovf"},       64'(bus.ovf),       64'd0);
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs, ren, rfl, riv;
    n_tests  = 0;
    n_fail   = 0;
    adv      = 0;
    exp_ov   = 1'b0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    rst_n    = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Reset state, then release away from the rising edge.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Carry ripples through every slice; signed overflow both ways.
    issue_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    issue_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    issue_exp(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue_exp(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue_exp(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    idle(NSTG + 1);

    // Stall mid-flight; in_valid while stalled must be ignored.
    issue_exp(32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
      tick(model(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0));
    end
    idle(NSTG + 1);

    // Flush on the second op's issue cycle drops ops 1 and 2, not op 3.
    issue(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0002, 1'b0, 1'b0);
    tick(model(32'h0000_2000, 32'h0000_0002, 1'b0, 1'b0));
    issue_exp(32'h0000_3000, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_3003, 1'b0, 1'b0);
    idle(NSTG + 1);

    // Back-to-back random stream with mixed modes.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, rs);
    end

    // Random stalls, bubbles and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      ra  = $urandom; rb = $urandom;
      rc  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      ren = ($urandom_range(0, 99) < 85);
      riv = ($urandom_range(0, 99) < 80);
      rfl = ($urandom_range(0, 99) < 3);
      apply_stimulus(ren, rfl, riv, ra, rb, rc, rs);
      tick(model(ra, rb, rc, rs));
    end
    idle(NSTG + 1);

    // Asynchronous reset between edges with four ops in flight.
    for (int i = 0; i < NSTG; i++) begin
      issue(32'h0101_0101 * (i + 1), 32'h7F7F_7F7F, 1'b1, 1'b0);
    end
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    exp_ov = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(NSTG + 2);
    issue_exp(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);

    // Drain whatever is still expected, bounded.
    for (int i = 0; i < 2 * NSTG && sb.size() > 0; i++) begin
      idle(1);
    end
    if (sb.size() != 0) begin
      check_output("drain_empty", 64'(sb.size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
